// File: rtl/ycbcr_to_rgb_conversion.sv
// BT.601 studio-range YCbCr to 8-bit RGB converter.
// Fixed 3-stage pipeline (offset removal, coefficient products, round/shift/clamp) with a valid tag.
module ycbcr_to_rgb_conversion #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MULT_PRECISION = 8,
    parameter int unsigned Y_OFFSET       = 16,
    parameter int unsigned C_OFFSET       = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] cb_in,
    input  logic [DATA_WIDTH-1:0] cr_in,
    output logic [DATA_WIDTH-1:0] red,
    output logic [DATA_WIDTH-1:0] green,
    output logic [DATA_WIDTH-1:0] blue,
    output logic                  data_valid_out
);

    localparam int unsigned W   = DATA_WIDTH;
    localparam int unsigned D_W = DATA_WIDTH + 1;
    localparam int unsigned P_W = 20;

    localparam logic signed [P_W-1:0] K_Y    = P_W'(298);
    localparam logic signed [P_W-1:0] K_RE   = P_W'(409);
    localparam logic signed [P_W-1:0] K_GD   = P_W'(100);
    localparam logic signed [P_W-1:0] K_GE   = P_W'(208);
    localparam logic signed [P_W-1:0] K_BD   = P_W'(516);
    localparam logic signed [P_W-1:0] ROUND  = P_W'(1 << (MULT_PRECISION - 1));
    localparam logic signed [P_W-1:0] PIXMAX = P_W'((1 << DATA_WIDTH) - 1);

    // Saturate a shifted signed sum into the unsigned component range.
    function automatic logic [W-1:0] clamp_pix(input logic signed [P_W-1:0] s);
        logic [W-1:0] res;
        res = s[W-1:0];
        if (s < P_W'(0)) begin
            res = '0;
        end else if (s > PIXMAX) begin
            res = '1;
        end
        return res;
    endfunction

    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic                  dv_out_q, dv_out_d;

    logic signed [D_W-1:0] c_q, c_d;
    logic signed [D_W-1:0] d_q, d_d;
    logic signed [D_W-1:0] e_q, e_d;

    logic signed [P_W-1:0] p_yc_q, p_yc_d;
    logic signed [P_W-1:0] p_re_q, p_re_d;
    logic signed [P_W-1:0] p_gd_q, p_gd_d;
    logic signed [P_W-1:0] p_ge_q, p_ge_d;
    logic signed [P_W-1:0] p_bd_q, p_bd_d;

    logic [W-1:0]          red_q, red_d;
    logic [W-1:0]          green_q, green_d;
    logic [W-1:0]          blue_q, blue_d;

    logic signed [P_W-1:0] sum_r_c, sum_g_c, sum_b_c;

    // Next-state: every stage holds unless its own valid tag is set.
    always_comb begin
        v1_d     = data_valid_in;
        v2_d     = v1_q;
        dv_out_d = v2_q;

        c_d      = c_q;
        d_d      = d_q;
        e_d      = e_q;
        p_yc_d   = p_yc_q;
        p_re_d   = p_re_q;
        p_gd_d   = p_gd_q;
        p_ge_d   = p_ge_q;
        p_bd_d   = p_bd_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;

        sum_r_c  = p_yc_q + p_re_q + ROUND;
        sum_g_c  = p_yc_q - p_gd_q - p_ge_q + ROUND;
        sum_b_c  = p_yc_q + p_bd_q + ROUND;

        if (data_valid_in) begin
            c_d = $signed({1'b0, y_in})  - $signed(D_W'(Y_OFFSET));
            d_d = $signed({1'b0, cb_in}) - $signed(D_W'(C_OFFSET));
            e_d = $signed({1'b0, cr_in}) - $signed(D_W'(C_OFFSET));
        end

        if (v1_q) begin
            p_yc_d = P_W'(c_q) * K_Y;
            p_re_d = P_W'(e_q) * K_RE;
            p_gd_d = P_W'(d_q) * K_GD;
            p_ge_d = P_W'(e_q) * K_GE;
            p_bd_d = P_W'(d_q) * K_BD;
        end

        if (v2_q) begin
            red_d   = clamp_pix(sum_r_c >>> MULT_PRECISION);
            green_d = clamp_pix(sum_g_c >>> MULT_PRECISION);
            blue_d  = clamp_pix(sum_b_c >>> MULT_PRECISION);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            dv_out_q <= 1'b0;
            c_q      <= '0;
            d_q      <= '0;
            e_q      <= '0;
            p_yc_q   <= '0;
            p_re_q   <= '0;
            p_gd_q   <= '0;
            p_ge_q   <= '0;
            p_bd_q   <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            dv_out_q <= dv_out_d;
            c_q      <= c_d;
            d_q      <= d_d;
            e_q      <= e_d;
            p_yc_q   <= p_yc_d;
            p_re_q   <= p_re_d;
            p_gd_q   <= p_gd_d;
            p_ge_q   <= p_ge_d;
            p_bd_q   <= p_bd_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign red            = red_q;
    assign green          = green_q;
    assign blue           = blue_q;
    assign data_valid_out = dv_out_q;

endmodule

// File: tb/tb_ycbcr_to_rgb_conversion.sv
// Bench for ycbcr_to_rgb_conversion: directed vectors, valid-pattern and reset sequences,
// random full-range pixels and an RGB->YCbCr->RGB loopback, all checked every cycle against a model.
module tb_ycbcr_to_rgb_conversion;

    localparam int HN = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid_in;
    logic [7:0] y_in, cb_in, cr_in;
    logic [7:0] red, green, blue;
    logic       data_valid_out;

    ycbcr_to_rgb_conversion dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (data_valid_in),
        .y_in           (y_in),
        .cb_in          (cb_in),
        .cr_in          (cr_in),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .data_valid_out (data_valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y, cb, cr;
        logic [7:0] r, g, b;
    } vec_t;

    bit          vin_h [HN];
    logic [23:0] pix_h [HN];
    bit          dvo_h [HN];
    int          last_rst = -1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          lb_mode = 1'b0;
    logic [23:0] lb_q [$];

    function automatic logic [7:0] clamp8(input int v);
        logic [7:0] r;
        if (v < 0)        r = 8'd0;
        else if (v > 255) r = 8'd255;
        else              r = 8'(v);
        return r;
    endfunction

    // Integer BT.601 inverse, straight from the conversion equations.
    function automatic logic [23:0] ref_rgb(input logic [23:0] p);
        int c, d, e;
        c = int'(p[23:16]) - 16;
        d = int'(p[15:8])  - 128;
        e = int'(p[7:0])   - 128;
        return {clamp8((298*c + 409*e + 128) >>> 8),
                clamp8((298*c - 100*d - 208*e + 128) >>> 8),
                clamp8((298*c + 516*d + 128) >>> 8)};
    endfunction

    // Forward BT.601 RGB -> studio-range YCbCr, standing in for the upstream converter.
    function automatic logic [23:0] fwd(input logic [23:0] rgb);
        int r, g, b, y, cb, cr;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        y  = ((66*r + 129*g + 25*b + 128) >>> 8) + 16;
        cb = ((-38*r - 74*g + 112*b + 128) >>> 8) + 128;
        cr = ((112*r - 94*g - 18*b + 128) >>> 8) + 128;
        return {8'(y), 8'(cb), 8'(cr)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected output after edge m: valid iff a pixel entered 2 edges earlier with no reset since;
    // colour is that of the latest pixel that has reached the output since the last reset.
    task automatic model_check();
        int          m;
        bit          exp_v;
        logic [23:0] exp_pix;
        int          ad;
        logic [23:0] orig;
        m = cyc;
        if (last_rst < 0) return;
        exp_v   = (m - 2 > last_rst) && vin_h[m-2];
        exp_pix = 24'd0;
        for (int j = m - 2; j > last_rst; j--) begin
            if (vin_h[j]) begin
                exp_pix = ref_rgb(pix_h[j]);
                break;
            end
        end
        chk("valid_out", 32'(data_valid_out), 32'(exp_v));
        chk("rgb_out", 32'({red, green, blue}), 32'(exp_pix));
        if (lb_mode && data_valid_out === 1'b1) begin
            if (lb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lb_underflow cycle=%0d actual=extra_pixel expected=none", cyc);
            end else begin
                orig = lb_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    ad = int'({red, green, blue} >> (8*k) & 24'hff) - int'(orig >> (8*k) & 24'hff);
                    if (ad < 0) ad = -ad;
                    chk("lb_tolerance", 32'(ad <= 3), 32'd1);
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [23:0] p, input bit r);
        data_valid_in = v;
        {y_in, cb_in, cr_in} = p;
        reset = r;
        @(posedge clk);
        if (cyc >= HN) begin
            $display("FAIL history_overflow cycle=%0d limit=%0d", cyc, HN);
            $fatal(1);
        end
        vin_h[cyc] = v;
        pix_h[cyc] = p;
        if (r) last_rst = cyc;
        #1;
        model_check();
        dvo_h[cyc] = data_valid_out;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'($urandom), 1'b0);
    endtask

    vec_t        tbl [6];
    bit          pat [7];
    logic [23:0] px, rgb;
    int          sent;

    initial begin
        tbl[0] = '{8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        tbl[1] = '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        tbl[2] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
        tbl[3] = '{8'd81,  8'd90,  8'd240, 8'd255, 8'd0,   8'd0};
        tbl[4] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd125, 8'd255};
        tbl[5] = '{8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130};
        pat    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        data_valid_in = 1'b0;
        reset = 1'b1;
        {y_in, cb_in, cr_in} = 24'd0;
        step(1'b0, 24'd0, 1'b1);
        step(1'b0, 24'd0, 1'b1);
        idle(3);

        // Directed vectors: single pixel, latency exactly 3 edges, value then held.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, {tbl[i].y, tbl[i].cb, tbl[i].cr}, 1'b0);
            step(1'b0, 24'd0, 1'b0);
            chk("tbl_early", 32'(data_valid_out), 32'd0);
            step(1'b0, 24'd0, 1'b0);
            chk("tbl_valid", 32'(data_valid_out), 32'd1);
            chk("tbl_rgb", 32'({red, green, blue}), 32'({tbl[i].r, tbl[i].g, tbl[i].b}));
            step(1'b0, 24'd0, 1'b0);
            chk("tbl_hold", 32'({red, green, blue}), 32'({tbl[i].r, tbl[i].g, tbl[i].b}));
        end

        // Gapped valid pattern comes out unchanged, 2 edges behind.
        begin
            int start;
            start = cyc;
            for (int i = 0; i < 7; i++) step(pat[i], 24'($urandom), 1'b0);
            idle(3);
            for (int i = 0; i < 7; i++) chk("pattern", 32'(dvo_h[start+i+2]), 32'(pat[i]));
        end

        // Reset with two pixels in flight, then first pixel afterwards.
        step(1'b1, 24'h51_5a_f0, 1'b0);
        step(1'b1, 24'heb_80_80, 1'b0);
        step(1'b0, 24'd0, 1'b1);
        chk("rst_rgb_zero", 32'({red, green, blue}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'd0, 1'b0);
            chk("rst_no_stale", 32'(data_valid_out), 32'd0);
        end
        px = 24'hb4_3c_c8;
        step(1'b1, px, 1'b0);
        step(1'b0, 24'd0, 1'b0);
        chk("post_rst_early", 32'(data_valid_out), 32'd0);
        step(1'b0, 24'd0, 1'b0);
        chk("post_rst_valid", 32'(data_valid_out), 32'd1);
        chk("post_rst_rgb", 32'({red, green, blue}), 32'(ref_rgb(px)));

        // Reset and valid together: pixel dropped.
        step(1'b1, 24'hff_ff_ff, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'd0, 1'b0);
            chk("rst_wins", 32'(data_valid_out), 32'd0);
        end

        // Random full-range pixels with random gaps and occasional resets.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 63) == 0);
        idle(3);

        // Loopback of random RGB through the forward conversion.
        lb_mode = 1'b1;
        sent = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                rgb = 24'($urandom);
                lb_q.push_back(rgb);
                step(1'b1, fwd(rgb), 1'b0);
                sent++;
            end else begin
                step(1'b0, 24'($urandom), 1'b0);
            end
        end
        idle(4);
        lb_mode = 1'b0;
        chk("lb_drain", 32'(lb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
